// File: rtl/reg_bus_read_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// reg_bus_read_arbiter_pkg
// Shared definitions for the register read-bus arbiter:
//   state_e  - sequencer state encoding (IDLE/DRIVE/CAPTURE/TURN)
//   CntWidth - width of the settle counter (covers SettleCycles up to 15)
// ---------------------------------------------------------------------------
package reg_bus_read_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DRIVE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_TURN    = 2'd3
   } state_e;

   localparam int CntWidth = 4;

endpackage

// File: rtl/reg_bus_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_bus_read_arbiter_if
// Bundles the requester-side handshake and the shared read bus.
//   Tick      - clock-enable tick from the system
//   Req       - per-register read request, held until Ack
//   BusIn     - resolved value of the shared tristate bus
//   cs        - per-register tristate control (1 = Hi-Z, 0 = drive)
//   Grant     - one-hot current owner, 0 when idle
//   Ack       - one-cycle pulse to the owner when DataOut is valid
//   DataOut   - captured bus value
//   DataValid - one-cycle pulse coincident with Ack
//   Busy      - high whenever the sequencer is not idle
// slave  : arbiter side.  master : system/requester side.
// ---------------------------------------------------------------------------
interface reg_bus_read_arbiter_if #(
   parameter int NrOfRequesters = 4,
   parameter int NrOfBits       = 32
) ();
   logic                      Tick;
   logic [NrOfRequesters-1:0] Req;
   logic [NrOfBits-1:0]       BusIn;
   logic [NrOfRequesters-1:0] cs;
   logic [NrOfRequesters-1:0] Grant;
   logic [NrOfRequesters-1:0] Ack;
   logic [NrOfBits-1:0]       DataOut;
   logic                      DataValid;
   logic                      Busy;

   modport slave (
      input  Tick, Req, BusIn,
      output cs, Grant, Ack, DataOut, DataValid, Busy
   );

   modport master (
      output Tick, Req, BusIn,
      input  cs, Grant, Ack, DataOut, DataValid, Busy
   );
endinterface

// File: rtl/reg_bus_read_arbiter_rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin selector: finds the first set request bit
// searching upward from ptr_i+1, wrapping modulo N.
//   req_i    - request vector
//   ptr_i    - index of the most recent winner
//   onehot_o - one-hot winner (0 when no request)
//   idx_o    - binary index of the winner
//   any_o    - at least one request present
// ---------------------------------------------------------------------------
module rr_priority_pick #(
   parameter  int N    = 4,
   localparam int PtrW = $clog2(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [PtrW-1:0] ptr_i,
   output logic [N-1:0]    onehot_o,
   output logic [PtrW-1:0] idx_o,
   output logic            any_o
);

   // One extra bit so ptr+offset (at most 2N-1) never overflows before wrap.
   logic [PtrW:0] cand_s;

   // Walk offsets 1..N from the pointer; the first hit wins.
   always_comb begin
      onehot_o = {N{1'b0}};
      idx_o    = {PtrW{1'b0}};
      any_o    = 1'b0;
      cand_s   = {(PtrW+1){1'b0}};
      for (int i = 1; i <= N; i++) begin
         cand_s = {1'b0, ptr_i} + (PtrW+1)'(i);
         if (cand_s >= (PtrW+1)'(N)) begin
            cand_s = cand_s - (PtrW+1)'(N);
         end else begin
            cand_s = cand_s;
         end
         if (!any_o && req_i[cand_s[PtrW-1:0]]) begin
            any_o    = 1'b1;
            idx_o    = cand_s[PtrW-1:0];
            onehot_o = N'(1) << cand_s[PtrW-1:0];
         end else begin
            any_o    = any_o;
         end
      end
   end

endmodule

// File: rtl/reg_bus_read_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bus_read_arbiter
// Round-robin sequencer for a shared tristate read bus fed by N registers.
// Grants one register at a time, lets the bus settle, captures it, acks the
// owner, then inserts a turnaround cycle before the next grant.
//   Clock - rising-edge system clock
//   Reset - synchronous, active-low
//   bus   - reg_bus_read_arbiter_if.slave (Tick, Req, BusIn in;
//           cs, Grant, Ack, DataOut, DataValid, Busy out)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module reg_bus_read_arbiter
   import reg_bus_read_arbiter_pkg::*;
#(
   parameter int NrOfRequesters = 4,
   parameter int NrOfBits       = 32,
   parameter int SettleCycles   = 1
) (
   input logic                   Clock,
   input logic                   Reset,
   reg_bus_read_arbiter_if.slave bus
);

   localparam int                        PtrW    = $clog2(NrOfRequesters);
   localparam logic [CntWidth-1:0]       LastCnt = CntWidth'(SettleCycles - 1);
   localparam logic [NrOfRequesters-1:0] AllHiZ  = {NrOfRequesters{1'b1}};
   localparam logic [NrOfRequesters-1:0] NoneSet = {NrOfRequesters{1'b0}};

   state_e                    state_q;
   logic [PtrW-1:0]           ptr_q;     // last winner; also the current owner
   logic [CntWidth-1:0]       cnt_q;
   logic [NrOfRequesters-1:0] cs_q;
   logic [NrOfRequesters-1:0] grant_q;
   logic [NrOfRequesters-1:0] ack_q;
   logic [NrOfBits-1:0]       data_q;
   logic                      dv_q;
   logic                      busy_q;

   logic [NrOfRequesters-1:0] pick_onehot_d;
   logic [PtrW-1:0]           pick_idx_d;
   logic                      any_req_d;

   rr_priority_pick #(
      .N (NrOfRequesters)
   ) u_pick (
      .req_i    (bus.Req),
      .ptr_i    (ptr_q),
      .onehot_o (pick_onehot_d),
      .idx_o    (pick_idx_d),
      .any_o    (any_req_d)
   );

   // Sequencer, settle counter, pointer, capture register and output decode.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= PtrW'(NrOfRequesters - 1);
         cnt_q   <= {CntWidth{1'b0}};
         cs_q    <= AllHiZ;
         grant_q <= NoneSet;
         ack_q   <= NoneSet;
         data_q  <= {NrOfBits{1'b0}};
         dv_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         // Ack/DataValid are single-cycle pulses; only the capture edge sets them.
         ack_q <= NoneSet;
         dv_q  <= 1'b0;
         if (bus.Tick) begin
            case (state_q)
               ST_IDLE: begin
                  if (any_req_d) begin
                     state_q <= ST_DRIVE;
                     grant_q <= pick_onehot_d;
                     cs_q    <= ~pick_onehot_d;
                     ptr_q   <= pick_idx_d;
                     cnt_q   <= {CntWidth{1'b0}};
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
               ST_DRIVE: begin
                  cnt_q <= cnt_q + CntWidth'(1);
                  // A withdrawn request wins over capture: release the bus, no Ack.
                  if (!bus.Req[ptr_q]) begin
                     state_q <= ST_TURN;
                     cs_q    <= AllHiZ;
                     grant_q <= NoneSet;
                  end else if (cnt_q == LastCnt) begin
                     state_q <= ST_CAPTURE;
                     data_q  <= bus.BusIn;
                     ack_q   <= grant_q;
                     dv_q    <= 1'b1;
                  end else begin
                     state_q <= ST_DRIVE;
                  end
               end
               ST_CAPTURE: begin
                  state_q <= ST_TURN;
                  cs_q    <= AllHiZ;
                  grant_q <= NoneSet;
               end
               ST_TURN: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= ST_IDLE;
                  cs_q    <= AllHiZ;
                  grant_q <= NoneSet;
                  busy_q  <= 1'b0;
               end
            endcase
         end else begin
            state_q <= state_q;
         end
      end
   end

   assign bus.cs        = cs_q;
   assign bus.Grant     = grant_q;
   assign bus.Ack       = ack_q;
   assign bus.DataOut   = data_q;
   assign bus.DataValid = dv_q;
   assign bus.Busy      = busy_q;

endmodule

// File: tb/tb_reg_bus_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_bus_read_arbiter
// Two arbiter instances: dut_a (SettleCycles=1) and dut_b (SettleCycles=3).
// Stimulus pushes expected grants/acks/data into per-DUT queues; a negedge
// monitor pops and compares whenever a grant starts or an Ack appears, and
// checks the bus invariants every cycle.
// ---------------------------------------------------------------------------
module tb_reg_bus_read_arbiter;

   logic clk;
   logic rst_n;
   bit   mon_en;
   bit   gate_tick;
   int   cyc;
   int   n_checks;
   int   n_fail;
   int   ack_seen [2];
   logic [3:0] prev_grant [2];
   logic tick_edge_a;
   logic tick_edge_b;

   logic [3:0]  eg_a [$];
   logic [3:0]  ea_a [$];
   logic [31:0] ed_a [$];
   logic [3:0]  eg_b [$];
   logic [3:0]  ea_b [$];
   logic [31:0] ed_b [$];

   reg_bus_read_arbiter_if #(.NrOfRequesters(4), .NrOfBits(32)) ifa ();
   reg_bus_read_arbiter_if #(.NrOfRequesters(4), .NrOfBits(32)) ifb ();

   reg_bus_read_arbiter #(.NrOfRequesters(4), .NrOfBits(32), .SettleCycles(1)) dut_a (
      .Clock (clk),
      .Reset (rst_n),
      .bus   (ifa)
   );

   reg_bus_read_arbiter #(.NrOfRequesters(4), .NrOfBits(32), .SettleCycles(3)) dut_b (
      .Clock (clk),
      .Reset (rst_n),
      .bus   (ifb)
   );

   // Contents of the four source registers.
   function automatic logic [31:0] reg_val(input int i);
      case (i)
         0:       reg_val = 32'h1111_0000;
         1:       reg_val = 32'h2222_0001;
         2:       reg_val = 32'hDEAD_BEEF;
         3:       reg_val = 32'h4444_0003;
         default: reg_val = 32'h0000_0000;
      endcase
   endfunction

   // Resolved tristate bus: OR of every register whose cs is low.
   function automatic logic [31:0] bus_mux(input logic [3:0] cs);
      logic [31:0] r;
      r = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (!cs[i]) r = r | reg_val(i);
      end
      return r;
   endfunction

   assign ifa.BusIn = bus_mux(ifa.cs);
   assign ifb.BusIn = bus_mux(ifb.cs);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   // Tick generator: every 3rd cycle when gated, otherwise always on.
   initial begin
      ifa.Tick = 1'b1;
      ifb.Tick = 1'b1;
      cyc = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         ifa.Tick = gate_tick ? (cyc % 3 == 0) : 1'b1;
      end
   end

   // Tick value seen at each active edge, for the ack-on-tick check.
   always @(posedge clk) begin
      tick_edge_a <= ifa.Tick;
      tick_edge_b <= ifb.Tick;
   end

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input int d, input logic [3:0] g, input bit with_ack, input logic [31:0] data);
      if (d == 0) begin
         eg_a.push_back(g);
         if (with_ack) begin ea_a.push_back(g); ed_a.push_back(data); end
      end else begin
         eg_b.push_back(g);
         if (with_ack) begin ea_b.push_back(g); ed_b.push_back(data); end
      end
   endtask

   task automatic mon_check(input int d, input string p, input logic [3:0] cs, input logic [3:0] grant,
                            input logic [3:0] ack, input logic dv, input logic [31:0] dout, input logic tick_edge);
      logic [3:0]  eg;
      logic [3:0]  ea;
      logic [31:0] ed;
      bit          has;
      check($countones(~cs) <= 1, {p, "cs_at_most_one_low"}, 64'(cs), 64'(~grant));
      check(cs == ~grant, {p, "cs_vs_grant"}, 64'(cs), 64'(~grant));
      check((ack & ~grant) == 4'b0000, {p, "ack_subset_grant"}, 64'(ack), 64'(grant));
      check(dv == (ack != 4'b0000), {p, "dv_with_ack"}, 64'(dv), 64'(ack != 4'b0000));
      if (ack != 4'b0000) begin
         ack_seen[d]++;
         check(tick_edge == 1'b1, {p, "ack_after_tick_edge"}, 64'(tick_edge), 64'd1);
         has = (d == 0) ? (ea_a.size() > 0) : (ea_b.size() > 0);
         check(has, {p, "unexpected_ack"}, 64'(ack), 64'd0);
         if (has) begin
            if (d == 0) begin ea = ea_a.pop_front(); ed = ed_a.pop_front(); end
            else        begin ea = ea_b.pop_front(); ed = ed_b.pop_front(); end
            check(ack == ea, {p, "ack_value"}, 64'(ack), 64'(ea));
            check(dout == ed, {p, "ack_data"}, 64'(dout), 64'(ed));
         end
      end
      if (grant != 4'b0000 && prev_grant[d] == 4'b0000) begin
         has = (d == 0) ? (eg_a.size() > 0) : (eg_b.size() > 0);
         check(has, {p, "unexpected_grant"}, 64'(grant), 64'd0);
         if (has) begin
            eg = (d == 0) ? eg_a.pop_front() : eg_b.pop_front();
            check(grant == eg, {p, "grant_order"}, 64'(grant), 64'(eg));
         end
      end
      prev_grant[d] = grant;
   endtask

   // Monitor: mid-cycle sampling of both DUTs.
   always @(negedge clk) begin
      if (mon_en) begin
         mon_check(0, "a_", ifa.cs, ifa.Grant, ifa.Ack, ifa.DataValid, ifa.DataOut, tick_edge_a);
         mon_check(1, "b_", ifb.cs, ifb.Grant, ifb.Ack, ifb.DataValid, ifb.DataOut, tick_edge_b);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input int d, input int n, input int budget, input string name);
      int start;
      int k;
      start = ack_seen[d];
      k = 0;
      while (ack_seen[d] < start + n && k < budget) begin
         step();
         k++;
      end
      check(ack_seen[d] >= start + n, {name, "_ack_count"}, 64'(ack_seen[d] - start), 64'(n));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      mon_en = 1'b0;
      gate_tick = 1'b0;
      ack_seen[0] = 0;
      ack_seen[1] = 0;
      prev_grant[0] = 4'b0000;
      prev_grant[1] = 4'b0000;
      rst_n = 1'b0;
      ifa.Req = 4'b0000;
      ifb.Req = 4'b0000;
      step();
      step();
      // Reset state
      check(ifa.cs == 4'b1111, "reset_cs", 64'(ifa.cs), 64'hF);
      check(ifa.Grant == 4'b0000, "reset_grant", 64'(ifa.Grant), 64'h0);
      check(ifa.Ack == 4'b0000, "reset_ack", 64'(ifa.Ack), 64'h0);
      check(ifa.DataValid == 1'b0, "reset_dv", 64'(ifa.DataValid), 64'h0);
      check(ifa.DataOut == 32'h0, "reset_dataout", 64'(ifa.DataOut), 64'h0);
      check(ifa.Busy == 1'b0, "reset_busy", 64'(ifa.Busy), 64'h0);
      mon_en = 1'b1;
      rst_n = 1'b1;
      step();

      // 1: single request from register 2
      ifa.Req = 4'b0100;
      push_exp(0, 4'b0100, 1'b1, 32'hDEAD_BEEF);
      step();
      check(ifa.cs == 4'b1011, "s1_cs_drive", 64'(ifa.cs), 64'hB);
      check(ifa.Busy == 1'b1, "s1_busy", 64'(ifa.Busy), 64'h1);
      step();
      check(ifa.Ack == 4'b0100, "s1_ack", 64'(ifa.Ack), 64'h4);
      check(ifa.DataOut == 32'hDEAD_BEEF, "s1_data", 64'(ifa.DataOut), 64'hDEADBEEF);
      ifa.Req = 4'b0000;
      step();
      check(ifa.cs == 4'b1111, "s1_cs_turn", 64'(ifa.cs), 64'hF);
      check(ifa.Busy == 1'b1, "s1_busy_turn", 64'(ifa.Busy), 64'h1);
      step();
      check(ifa.Busy == 1'b0, "s1_idle", 64'(ifa.Busy), 64'h0);

      // 3: dut_b, one good read then an aborted one
      ifb.Req = 4'b0001;
      push_exp(1, 4'b0001, 1'b1, 32'h1111_0000);
      wait_ack(1, 1, 30, "s3_first");
      ifb.Req = 4'b0000;
      repeat (3) step();
      ifb.Req = 4'b0100;
      push_exp(1, 4'b0100, 1'b0, 32'h0);
      step();
      check(ifb.cs == 4'b1011, "s3_cs_drive0", 64'(ifb.cs), 64'hB);
      step();
      check(ifb.cs == 4'b1011, "s3_cs_drive1", 64'(ifb.cs), 64'hB);
      ifb.Req = 4'b0000;
      step();
      check(ifb.cs == 4'b1111, "s3_cs_turn", 64'(ifb.cs), 64'hF);
      check(ifb.Grant == 4'b0000, "s3_grant_turn", 64'(ifb.Grant), 64'h0);
      check(ifb.Busy == 1'b1, "s3_busy_turn", 64'(ifb.Busy), 64'h1);
      check(ifb.DataOut == 32'h1111_0000, "s3_data_kept", 64'(ifb.DataOut), 64'h11110000);
      step();
      check(ifb.Busy == 1'b0, "s3_idle", 64'(ifb.Busy), 64'h0);
      repeat (4) step();
      check(ifb.DataOut == 32'h1111_0000, "s3_data_final", 64'(ifb.DataOut), 64'h11110000);

      // 2: all requesting, fresh pointer
      do_reset();
      ifa.Req = 4'b1111;
      for (int i = 0; i < 5; i++) push_exp(0, 4'b0001 << (i % 4), 1'b1, reg_val(i % 4));
      wait_ack(0, 5, 60, "s2");
      ifa.Req = 4'b0000;
      repeat (4) step();

      // 5: same traffic with Tick every third cycle
      do_reset();
      gate_tick = 1'b1;
      ifa.Req = 4'b1111;
      for (int i = 0; i < 5; i++) push_exp(0, 4'b0001 << (i % 4), 1'b1, reg_val(i % 4));
      wait_ack(0, 5, 200, "s5");
      ifa.Req = 4'b0000;
      repeat (12) step();
      gate_tick = 1'b0;
      repeat (2) step();

      // 4: reset while driving, then pointer restarts at requester 0
      ifa.Req = 4'b0100;
      push_exp(0, 4'b0100, 1'b0, 32'h0);
      step();
      check(ifa.cs == 4'b1011, "s4_cs_drive", 64'(ifa.cs), 64'hB);
      rst_n = 1'b0;
      step();
      check(ifa.cs == 4'b1111, "s4_cs_reset", 64'(ifa.cs), 64'hF);
      check(ifa.Busy == 1'b0, "s4_busy_reset", 64'(ifa.Busy), 64'h0);
      check(ifa.Grant == 4'b0000, "s4_grant_reset", 64'(ifa.Grant), 64'h0);
      check(ifa.Ack == 4'b0000, "s4_ack_reset", 64'(ifa.Ack), 64'h0);
      rst_n = 1'b1;
      ifa.Req = 4'b1111;
      push_exp(0, 4'b0001, 1'b1, 32'h1111_0000);
      wait_ack(0, 1, 20, "s4");
      ifa.Req = 4'b0000;
      repeat (5) step();

      check(eg_a.size() == 0, "a_grants_left", 64'(eg_a.size()), 64'd0);
      check(ea_a.size() == 0, "a_acks_left", 64'(ea_a.size()), 64'd0);
      check(eg_b.size() == 0, "b_grants_left", 64'(eg_b.size()), 64'd0);
      check(ea_b.size() == 0, "b_acks_left", 64'(ea_b.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
